// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with a per-grant hold limit.
// One requester owns the grant until it drops its request or has held it for
// MAX_HOLD consecutive cycles; the next owner is the lowest requesting bit
// strictly above the previous owner, wrapping to bit 0.
//
// Handshake: requests[i] is a level "valid" from requester i; grant[i] is the
// registered "ready/owner" answer. A requester owns the resource in every
// cycle its grant bit is high, and it releases the resource by dropping its
// request. Requests are not latched, so a request dropped before being
// granted is lost.
module rr_hold_arbiter #(
  parameter int WORD_WIDTH  = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int MAX_HOLD    = 3,
  parameter int COUNT_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [WORD_WIDTH-1:0]  requests,
  output logic [WORD_WIDTH-1:0]  grant,
  output logic                   grant_valid,
  output logic [INDEX_WIDTH-1:0] grant_index
);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  // state_q is the FSM state register, kept as a named enum for probing.
  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  grant_q, grant_d;
  logic [WORD_WIDTH-1:0]  last_q, last_d;
  logic [COUNT_WIDTH-1:0] hold_count_q, hold_count_d;
  logic                   grant_valid_q;
  logic [INDEX_WIDTH-1:0] grant_index_q, index_d;

  localparam logic [WORD_WIDTH-1:0]  LAST_RESET = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0] HOLD_LIMIT = COUNT_WIDTH'(MAX_HOLD);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  // Lowest candidate above the previous owner, else lowest candidate, else
  // lowest requester (lets an excluded sole requester be granted again).
  function automatic logic [WORD_WIDTH-1:0] pick(
    input logic [WORD_WIDTH-1:0] req,
    input logic [WORD_WIDTH-1:0] excl,
    input logic [WORD_WIDTH-1:0] prev
  );
    logic [WORD_WIDTH-1:0] above;
    logic [WORD_WIDTH-1:0] cand;
    logic [WORD_WIDTH-1:0] m;
    above = ~((prev << 1) - WORD_WIDTH'(1));
    cand  = req & ~excl;
    m     = cand & above;
    if (m != '0)         pick = m & (-m);
    else if (cand != '0) pick = cand & (-cand);
    else                 pick = req & (-req);
  endfunction

  logic holder_req;
  logic release_now;
  logic expire_now;
  logic [WORD_WIDTH-1:0] next_pick;

  assign holder_req  = (requests & grant_q) != '0;
  assign release_now = !holder_req;
  assign expire_now  = (MAX_HOLD != 0) && (hold_count_q == HOLD_LIMIT) && holder_req;

  // Next-state, next-grant and hold counter decisions.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    hold_count_d = hold_count_q;
    next_pick    = '0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (requests != '0) begin
          next_pick    = pick(requests, '0, last_q);
          grant_d      = next_pick;
          last_d       = next_pick;
          hold_count_d = COUNT_ONE;
          state_d      = GRANTED;
        end
      end
      GRANTED: begin
        if (release_now || expire_now) begin
          next_pick = pick(requests, grant_q, last_q);
          grant_d   = next_pick;
          if (next_pick != '0) begin
            last_d       = next_pick;
            hold_count_d = COUNT_ONE;
          end else begin
            hold_count_d = '0;
            state_d      = IDLE;
          end
        end else if ((MAX_HOLD != 0) && (hold_count_q < HOLD_LIMIT)) begin
          hold_count_d = hold_count_q + COUNT_ONE;
        end
      end
      default: begin
        state_d      = IDLE;
        grant_d      = '0;
        hold_count_d = '0;
      end
    endcase
  end

  // Binary encode of the one-hot next grant (0 when no grant).
  always_comb begin
    index_d = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (grant_d[i]) index_d = INDEX_WIDTH'(i);
    end
  end

  // State and registered outputs; clear forces everything to reset values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_q        <= LAST_RESET;
      hold_count_q  <= '0;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      hold_count_q  <= hold_count_d;
      grant_valid_q <= (grant_d != '0);
      grant_index_q <= index_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_index = grant_index_q;

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Registered round-robin arbiter that grants one requester at a time and holds the grant until the requester drops its request or a configurable hold limit expires. It shares a single resource, such as a memory port or I/O channel, among `WORD_WIDTH` requesters. Selection is by lowest-set-bit priority (`x & -x`) over a rotating mask, so a waiting requester is never starved.

## Interface
- `WORD_WIDTH`, 0: number of requesters; must be ≥ 2.
- `INDEX_WIDTH`, 0: width of `grant_index`; must equal clog2(`WORD_WIDTH`).
- `MAX_HOLD`, 0: maximum consecutive cycles one grant may be held; 0 means unlimited.
- `COUNT_WIDTH`, 0: hold counter width; must hold `MAX_HOLD` (≥ 1 even when `MAX_HOLD` = 0).
- `clock` input 1: sole clock; all state updates on the rising edge.
- `clear` input 1: asynchronous, active-high reset.
- `requests` input `WORD_WIDTH`: level request per requester; bit i = requester i.
- `grant` output `WORD_WIDTH`: registered grant; one-hot or zero.
- `grant_valid` output 1: registered; high exactly when `grant` is nonzero.
- `grant_index` output `INDEX_WIDTH`: registered binary index of the granted bit; 0 when `grant_valid` is low.

## Operation
- **State.** Each register and its `clear` value:
  - FSM: `IDLE` on reset, or `GRANTED`.
  - `grant`: 0.
  - `last`: one-hot, reset to MSB set, so the first arbitration favours bit 0.
  - `hold_count`: 0.
- **Arbitration function** `pick(req, excl)`:
  - `above` = bits strictly more significant than `last`, i.e. ~((`last` << 1) − 1) masked to `WORD_WIDTH`.
  - `cand` = `req` & ~`excl`.
  - `m` = `cand` & `above`.
  - Result = `m` & −`m` if `m` ≠ 0.
  - Otherwise `cand` & −`cand` if `cand` ≠ 0.
  - Otherwise `req` & −`req`. This is the fallback that re-grants an excluded sole requester.
- **`IDLE`:**
  - If `requests` ≠ 0: load `grant` = `pick(requests, 0)`, set `last` = that grant, `hold_count` = 1, go to `GRANTED`.
  - Otherwise stay in `IDLE` with `grant` = 0.
- **`GRANTED`, holder = `grant`:**
  - *Release*: (`requests` & `grant`) = 0.
    - Load `grant` = `pick(requests, grant)`.
    - If that result is zero, go to `IDLE`.
  - *Expiry*: `MAX_HOLD` ≠ 0, `hold_count` = `MAX_HOLD`, and the holder is still requesting.
    - Load `grant` = `pick(requests, grant)`.
    - If only the holder requests, the holder is re-granted.
  - *Otherwise*: keep `grant`; `hold_count` increments, saturating at `MAX_HOLD` when `MAX_HOLD` ≠ 0 and not incrementing when `MAX_HOLD` = 0.
  - On any new nonzero grant, including a re-grant: `last` = new grant, `hold_count` = 1.
- **`grant_index`** is the encoded new grant, registered alongside `grant`. **`grant_valid`** is registered as (new grant ≠ 0).
- **Request changes:**
  - Requests by non-holders during `GRANTED` have no effect on `grant`.
  - Requests are not latched; a request dropped before its grant is simply lost.
- **Error case.** A holder dropping its request in the same cycle as expiry is treated as release; the result is identical either way.
- **`clear` mid-operation:** every register immediately takes its reset value, regardless of the clock. `grant` drops to 0 asynchronously.

## Timing
- Latency from request to grant: 1 cycle. A request seen at edge N produces `grant` high after edge N.
- Handoff on release or expiry: zero dead cycles. The new grant appears at the same edge where the old one is removed.
- Release to `IDLE` (no other requesters): `grant` = 0 one cycle after the holder's request drops.
- With `MAX_HOLD` = H, a continuously requesting holder with contenders holds the grant for exactly H cycles.
- Worst-case wait for a continuously requesting requester, with `MAX_HOLD` = H: (`WORD_WIDTH` − 1)·H cycles from its first cycle of waiting.
- Outputs are purely registered; there is no combinational path from `requests` to `grant`.

## Test plan
- **Reset and first grant.** `WORD_WIDTH`=4, `MAX_HOLD`=3. Assert `clear`, then release it with `requests`=4'b1111.
  - One cycle later: `grant`=0001, `grant_index`=0, `grant_valid`=1.
  - `grant` = 0 asynchronously while `clear` is high.
- **Hold expiry and rotation.** Keep `requests`=1111.
  - Grant sequence 0001×3, 0010×3, 0100×3, 1000×3, then 0001, with no gap cycles.
- **Early release handoff.** Holder 0010 at `hold_count`=1; `requests` changes to 1101.
  - Next cycle `grant`=0100 (above `last`), `hold_count`=1.
- **Sole requester re-grant.** `requests`=0100 continuously.
  - `grant` stays 0100 indefinitely; `hold_count` cycles 1, 2, 3, 1; `grant_valid` never drops.
- **Return to `IDLE`.** Holder 1000 drops and `requests`=0000.
  - Next cycle `grant`=0, `grant_valid`=0, `grant_index`=0.
  - Later `requests`=0011 with `last`=1000 gives `grant`=0001.
- **`clear` mid-grant.** Pulse `clear` asynchronously while the grant is 0100 with `hold_count`=2.
  - Outputs go to 0 immediately.
  - After release with `requests`=1111: `grant`=0001.
